// File: rtl/mult_share_arb_if.sv
// mult_share_arb_if: handshake and result bundle between two requesters and mult_share_arb.
//   req0/a0/b0, req1/a1/b1 : requester operands and request strobes (requester -> arbiter)
//   gnt0/gnt1              : combinational issue grants (arbiter -> requester)
//   rvalid0/rvalid1        : one-cycle result-valid pulses, one per requester
//   result                 : registered 19-bit signed product shared by both requesters
//   busy                   : high while any issued product is still in flight
// Modports: master = requester side, slave = arbiter side.
interface mult_share_arb_if;
    logic        req0;
    logic [10:0] a0;
    logic [7:0]  b0;
    logic        gnt0;
    logic        req1;
    logic [10:0] a1;
    logic [7:0]  b1;
    logic        gnt1;
    logic        rvalid0;
    logic        rvalid1;
    logic [18:0] result;
    logic        busy;

    modport master (
        output req0, a0, b0, req1, a1, b1,
        input  gnt0, gnt1, rvalid0, rvalid1, result, busy
    );

    modport slave (
        input  req0, a0, b0, req1, a1, b1,
        output gnt0, gnt1, rvalid0, rvalid1, result, busy
    );
endinterface

// File: rtl/mult_share_arb.sv
// mult_share_arb: two-requester arbiter that time-shares one signed 11x8 multiplier.
// Issues at most one product per clock, tags each issue with the requester id and returns
// the registered product with a one-cycle rvalid pulse to the issuing requester.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mult_share_arb_if.slave (requests, operands, grants, result, rvalids, busy)
// Parameters:
//   MULT_LAT : multiplier latency in cycles (n1/n2 sampled -> result valid), >= 1
// Configuration macro:
//   MULT_ARB_FIXED_PRIO_EN : defined -> requester 0 always wins ties (no round-robin pointer)
//
// mult11sx8s: signed 11x8 multiplier, full 19-bit product, LAT register stages.
module mult11sx8s #(
    parameter int unsigned LAT = 1
) (
    input  logic        clk,
    input  logic [10:0] n1,
    input  logic [7:0]  n2,
    output logic [18:0] result
);
    logic signed [18:0] prod;
    logic        [18:0] pipe [LAT];

    // Operands are sign-extended to the 19-bit context before multiplying.
    assign prod = $signed(n1) * $signed(n2);

    always_ff @(posedge clk) begin
        pipe[0] <= prod;
        for (int i = 1; i < int'(LAT); i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    assign result = pipe[LAT-1];
endmodule

module mult_share_arb #(
    parameter int unsigned MULT_LAT = 1
) (
    input logic             clk,
    input logic             rst,
    mult_share_arb_if.slave bus
);
    localparam int unsigned Last = MULT_LAT - 1;

    logic              gnt0;
    logic              gnt1;
    logic              gnt_any;
    logic [10:0]       n1;
    logic [7:0]        n2;
    logic [18:0]       mult_out;
    logic [MULT_LAT-1:0] tag_v_q;
    logic [MULT_LAT-1:0] tag_id_q;
    logic [18:0]       result_q;
    logic              rvalid0_q;
    logic              rvalid1_q;
    logic              busy_q;

`ifndef MULT_ARB_FIXED_PRIO_EN
    logic prio_q;  // requester that wins the next tie
`endif

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
            gnt0 = bus.req0;
            gnt1 = bus.req1 & ~bus.req0;
`else
            gnt0 = bus.req0 & (~bus.req1 | ~prio_q);
            gnt1 = bus.req1 & (~bus.req0 | prio_q);
`endif
        end
    end

    assign gnt_any = gnt0 | gnt1;

    // Idle cycles feed zeros so the multiplier sees no stale operands.
    always_comb begin
        n1 = '0;
        n2 = '0;
        if (gnt0) begin
            n1 = bus.a0;
            n2 = bus.b0;
        end else if (gnt1) begin
            n1 = bus.a1;
            n2 = bus.b1;
        end
    end

    mult11sx8s #(
        .LAT (MULT_LAT)
    ) u_mult (
        .clk    (clk),
        .n1     (n1),
        .n2     (n2),
        .result (mult_out)
    );

`ifndef MULT_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else if (gnt0) begin
            prio_q <= 1'b1;
        end else if (gnt1) begin
            prio_q <= 1'b0;
        end
    end
`endif

    // Tag pipeline mirrors the multiplier latency; clearing it on reset is what drops
    // products still draining out of the multiplier.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v_q   <= '0;
            tag_id_q  <= '0;
            result_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            tag_v_q[0]  <= gnt_any;
            tag_id_q[0] <= gnt1;
            for (int i = 1; i < int'(MULT_LAT); i++) begin
                tag_v_q[i]  <= tag_v_q[i-1];
                tag_id_q[i] <= tag_id_q[i-1];
            end
            rvalid0_q <= tag_v_q[Last] & ~tag_id_q[Last];
            rvalid1_q <= tag_v_q[Last] & tag_id_q[Last];
            if (tag_v_q[Last]) begin
                result_q <= mult_out;
            end
            // Covers every cycle from issue+1 through the rvalid cycle.
            busy_q <= gnt_any | (|tag_v_q);
        end
    end

    assign bus.gnt0    = gnt0;
    assign bus.gnt1    = gnt1;
    assign bus.result  = result_q;
    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_mult_share_arb.sv
// tb_mult_share_arb: directed and randomized bench for mult_share_arb with a
// cycle-indexed scoreboard of expected grants, result pulses and busy.
module tb_mult_share_arb;
    localparam int unsigned MULT_LAT = 1;
    localparam int          MaxCyc   = 4096;

    logic clk;
    logic rst;
    mult_share_arb_if bus ();

    mult_share_arb #(
        .MULT_LAT (MULT_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Requester behaviour: pend held until granted; cnt requests left; pct request chance.
    logic        pend0, pend1;
    logic [10:0] opa0, opa1;
    logic [7:0]  opb0, opb1;
    logic [10:0] fa0, fa1;
    logic [7:0]  fb0, fb1;
    logic        rnd;
    int          cnt0, cnt1, pct0, pct1;

    // Reference model state.
    logic        m_prio;
    logic [18:0] m_result;
    int          busy_until;
    logic        due0   [MaxCyc];
    logic        due1   [MaxCyc];
    logic [18:0] dueval [MaxCyc];

    function automatic logic [18:0] ref_prod(input logic [10:0] a, input logic [7:0] b);
        int x, y, p;
        x = int'($signed(a));
        y = int'($signed(b));
        p = x * y;
        return p[18:0];
    endfunction

    task automatic chk(input string tag, input logic [18:0] got, input logic [18:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d got=%h want=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input logic r);
        logic g0, g1, e0, e1;
        @(posedge clk);
        #1;
        if (!pend0 && cnt0 > 0 && $urandom_range(99) < pct0) begin
            pend0 = 1'b1;
            cnt0--;
            opa0  = rnd ? 11'($urandom) : fa0;
            opb0  = rnd ? 8'($urandom) : fb0;
        end
        if (!pend1 && cnt1 > 0 && $urandom_range(99) < pct1) begin
            pend1 = 1'b1;
            cnt1--;
            opa1  = rnd ? 11'($urandom) : fa1;
            opb1  = rnd ? 8'($urandom) : fb1;
        end
        rst      = r;
        bus.req0 = pend0;
        bus.a0   = opa0;
        bus.b0   = opb0;
        bus.req1 = pend1;
        bus.a1   = opa1;
        bus.b1   = opb1;
        #3;
        g0 = 1'b0;
        g1 = 1'b0;
        if (!r) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
            g0 = pend0;
            g1 = pend1 && !pend0;
`else
            if (pend0 && pend1) begin
                g0 = (m_prio == 1'b0);
                g1 = !g0;
            end else begin
                g0 = pend0;
                g1 = pend1;
            end
`endif
        end
        e0 = due0[cyc];
        e1 = due1[cyc];
        if (e0 || e1) m_result = dueval[cyc];
        chk("gnt0", 19'(bus.gnt0), 19'(g0));
        chk("gnt1", 19'(bus.gnt1), 19'(g1));
        chk("rvalid0", 19'(bus.rvalid0), 19'(e0));
        chk("rvalid1", 19'(bus.rvalid1), 19'(e1));
        chk("result", bus.result, m_result);
        chk("busy", 19'(bus.busy), 19'(cyc <= busy_until));
        if (r) begin
            for (int k = cyc + 1; k <= cyc + int'(MULT_LAT) + 1; k++) begin
                due0[k] = 1'b0;
                due1[k] = 1'b0;
            end
            m_prio     = 1'b0;
            m_result   = '0;
            busy_until = cyc;
        end else if (g0 || g1) begin
            due0[cyc + int'(MULT_LAT) + 1]   = g0;
            due1[cyc + int'(MULT_LAT) + 1]   = g1;
            dueval[cyc + int'(MULT_LAT) + 1] = g0 ? ref_prod(opa0, opb0) : ref_prod(opa1, opb1);
            busy_until = cyc + int'(MULT_LAT) + 1;
            m_prio     = g0;
            if (g0) pend0 = 1'b0;
            if (g1) pend1 = 1'b0;
        end
        cyc++;
    endtask

    task automatic load(input int c0, input logic [10:0] a0v, input logic [7:0] b0v,
                        input int c1, input logic [10:0] a1v, input logic [7:0] b1v);
        cnt0 = c0; fa0 = a0v; fb0 = b0v; pct0 = 100;
        cnt1 = c1; fa1 = a1v; fb1 = b1v; pct1 = 100;
        rnd  = 1'b0;
    endtask

    task automatic idle(input int n);
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    initial begin
        for (int k = 0; k < MaxCyc; k++) begin
            due0[k] = 1'b0; due1[k] = 1'b0; dueval[k] = '0;
        end
        pend0 = 1'b0; pend1 = 1'b0;
        opa0 = '0; opb0 = '0; opa1 = '0; opb1 = '0;
        cnt0 = 0; cnt1 = 0; pct0 = 100; pct1 = 100; rnd = 1'b0;
        fa0 = '0; fb0 = '0; fa1 = '0; fb1 = '0;
        m_prio = 1'b0; m_result = '0; busy_until = -1;
        bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0;
        bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);

        // Single grant to requester 0, then idle checks reset-state outputs too.
        load(1, 11'h555, 8'h55, 0, '0, '0);
        step(1'b0);
        idle(4);

        // Tie held: alternating grants starting from requester 0 after reset.
        step(1'b1);
        load(2, 11'h2AA, 8'hAA, 2, 11'h7FF, 8'h80);
        for (int i = 0; i < 4; i++) step(1'b0);
        idle(4);

        // Requester 1 streaming alone.
        load(0, '0, '0, 5, 11'h7FF, 8'h7F);
        for (int i = 0; i < 5; i++) step(1'b0);
        idle(4);

        // Reset with products in flight, then tie goes to requester 0.
        load(2, 11'h123, 8'h45, 0, '0, '0);
        step(1'b0);
        step(1'b0);
        cnt0 = 0;
        step(1'b1);
        idle(4);
        load(1, 11'h011, 8'h03, 1, 11'h022, 8'h05);
        for (int i = 0; i < 2; i++) step(1'b0);
        idle(4);

        // Extreme and zero products.
        load(1, 11'h400, 8'h80, 0, '0, '0);
        step(1'b0);
        idle(3);
        load(1, 11'h000, 8'hFF, 0, '0, '0);
        step(1'b0);
        idle(4);

        // Randomized phases with occasional reset.
        for (int ph = 0; ph < 6; ph++) begin
            cnt0 = 40; cnt1 = 40; rnd = 1'b1;
            pct0 = int'($urandom_range(100));
            pct1 = int'($urandom_range(100));
            for (int i = 0; i < 80; i++) step($urandom_range(39) == 0);
            idle(6);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mult_share_arb.md
# mult_share_arb

Two-requester arbiter and sequencer that time-shares one `mult11sx8s` signed 11x8 multiplier, instantiated inside this block.
- Each requester presents operands with a request/grant handshake.
- The block issues at most one product per clock into the multiplier pipeline and tags each issue with the requester ID.
- Each result returns registered, with a one-cycle valid pulse to the requester that issued it.
- Sits between the datapath clients (e.g. filter tap engines) and the shared multiplier.

## Interface
Parameters:
- `MULT_LAT`, default 1: clock cycles from `n1`/`n2` sampled at a rising edge to `result` valid at the `mult11sx8s` output. Must match the instantiated multiplier.

Ports:
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0` in 1: requester 0 has operands pending; held until `gnt0`.
- `a0` in 11: requester 0 multiplicand, signed two's complement.
- `b0` in 8: requester 0 multiplier, signed.
- `gnt0` out 1: combinational; operands of requester 0 issued at this edge.
- `req1`, `a1`, `b1`, `gnt1`: same as the requester 0 ports, for requester 1.
- `rvalid0` out 1: one-cycle pulse; `result` belongs to requester 0.
- `rvalid1` out 1: one-cycle pulse; `result` belongs to requester 1.
- `result` out 19: registered signed product, holds its value between valid pulses.
- `busy` out 1: registered; high while any issued product is still in flight.

## Operation
- Arbitration each cycle:
  - Only one of `req0`/`req1` high: that requester is granted.
  - Both high: the requester named by priority pointer `prio` is granted.
  - `gnt0` and `gnt1` are never both high.
- Round-robin: after any grant, `prio` points to the other requester. With no grant, `prio` is unchanged. Reset value of `prio` is 0.
- Issue: the granted requester's `a`/`b` drive `n1`/`n2` that cycle. With no grant, `n1`/`n2` are driven to 0.
- Tag pipeline: `MULT_LAT` stages, each holding {valid, id}, shifted every clock.
  - Stage 0 input = {gnt0|gnt1, gnt1}.
- Completion: when the last tag stage is valid, the multiplier output is registered into `result` and `rvalid[id]` pulses high for exactly one cycle.
- Arithmetic: full-precision signed 11x8 product, 19 bits. There is no overflow. The worst case, -1024 x -128 = 131072, fits in 19 bits.
- Back-to-back: a requester holding `req` continuously is granted every cycle while the other is idle, and every other cycle while the other also requests. Throughput is one product per clock.
- Reset (synchronous):
  - `gnt0`/`gnt1` are forced to 0 while `rst` is high, regardless of `req`.
  - Tag pipeline cleared.
  - `result` = 0, `rvalid0` = `rvalid1` = 0, `busy` = 0, `prio` = 0.
  - Products in flight at reset are discarded; no `rvalid` is issued for them, even when the multiplier pipeline drains after reset.

## Timing
- Grant in cycle t (combinational, same cycle as a sampled `req`).
- `result` and `rvalidX` are valid in cycle t+`MULT_LAT`+1. Total latency is `MULT_LAT`+1 cycles.
- `busy` is high from cycle t+1 until the cycle after the last `rvalid` pulse.
- A requester must hold `req`, `a` and `b` stable until it sees `gnt` high. It may change them in the cycle after the grant.
- There is no result backpressure. Requesters must accept `rvalid` whenever it occurs.

## Configuration
- `MULT_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority. Requester 0 always wins ties, `prio` logic is removed, and requester 1 may starve.
  - Undefined (default): round-robin as specified above.

## Test plan
1. Reset, then `req0`=1 with `a0`=11'h555 and `b0`=8'h55 for one grant, `MULT_LAT`=1 -> `gnt0` in cycle 0; `result`=19'h71D39 with `rvalid0` in cycle 2; `busy` high in cycles 1-2.
2. `req0`=`req1`=1 held for 4 cycles; `a0`/`b0`=11'h2AA/8'hAA, `a1`/`b1`=11'h7FF/8'h80 -> grants alternate 0,1,0,1. Results alternate 19'h71AE4 (`rvalid0`) and 19'h00080 (`rvalid1`) on consecutive cycles.
3. `req1` held with `a1`=11'h7FF, `b1`=8'h7F, `req0` idle -> `gnt1` every cycle; every result 19'h7FF81 with `rvalid1` each cycle and no `rvalid0`.
4. Issue 2 products, then assert `rst` for 1 cycle while they are in flight -> no `rvalid` at the expected cycles; `result`=0, `busy`=0; the next grant goes to requester 0 on a tie.
5. Operands 11'h400 x 8'h80 -> `result`=19'h20000 (+131072). Operands 11'h000 x 8'hFF -> `result`=0 with `rvalid` still pulsed.
6. With `MULT_ARB_FIXED_PRIO_EN` defined, both requesters held for 3 cycles -> `gnt0` all 3 cycles and `gnt1` never.
